// File: rtl/mux8to1_rr_arbiter.sv
// Eight-channel packet-aware round-robin gather onto a single registered stream.
// Each output beat carries its source index so a downstream demux can split it again.
module mux8to1_rr_arbiter #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [7:0]     in_valid_i,
    input  logic [8*W-1:0] in_data_i,
    input  logic [7:0]     in_last_i,
    output logic [7:0]     in_ready_o,
    output logic           out_valid_o,
    output logic [W-1:0]   out_data_o,
    output logic [2:0]     out_sel_o,
    output logic           out_last_o,
    input  logic           out_ready_i,
    output logic           state_o,
    output logic [2:0]     ptr_o,
    output logic [2:0]     lch_o
);

    // Handshake: an input beat on channel k transfers when in_valid_i[k] && in_ready_o[k];
    // an output beat transfers when out_valid_o && out_ready_i. in_ready_o is at most one-hot.
    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [2:0]     lch_q, lch_d;
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    logic [2:0]     out_sel_q;
    logic           out_last_q;

    logic           load_en;
    logic           grant_any;
    logic [2:0]     grant_idx;
    logic [2:0]     cand;
    logic           accept;
    logic [W-1:0]   sel_data;

    assign load_en = !out_valid_q || out_ready_i;

    // Descending scan so the candidate closest to ptr_q is written last and wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state_q == ST_LOCKED) begin
            grant_any = in_valid_i[lch_q];
            grant_idx = lch_q;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                cand = ptr_q + 3'(i);
                if (in_valid_i[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign accept     = load_en && grant_any && !rst_i;
    assign in_ready_o = accept ? (8'b1 << grant_idx) : 8'b0;
    assign sel_data   = in_data_i[grant_idx*W +: W];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lch_d   = lch_q;
        if (accept) begin
            if (state_q == ST_ARB) begin
                if (in_last_i[grant_idx]) begin
                    ptr_d = grant_idx + 3'd1;
                end else begin
                    state_d = ST_LOCKED;
                    lch_d   = grant_idx;
                end
            end else if (in_last_i[lch_q]) begin
                state_d = ST_ARB;
                ptr_d   = lch_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_ARB;
            ptr_q       <= '0;
            lch_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lch_q   <= lch_d;
            if (load_en) begin
                out_valid_q <= accept;
                if (accept) begin
                    out_data_q <= sel_data;
                    out_sel_q  <= grant_idx;
                    out_last_q <= in_last_i[grant_idx];
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;
    assign out_last_o  = out_last_q;
    assign state_o     = (state_q == ST_LOCKED);
    assign ptr_o       = ptr_q;
    assign lch_o       = lch_q;

endmodule

// File: tb/tb_mux8to1_rr_arbiter.sv
// Bench for mux8to1_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a packet-level reference model.
module tb_mux8to1_rr_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     in_valid;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_last;
    logic           out_ready;
    logic [7:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_last;
    logic           state;
    logic [2:0]     ptr;
    logic [2:0]     lch;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_ptr, m_lch, m_os;
    bit         m_locked, m_ov, m_ol, m_known;
    logic [W-1:0] m_od;

    always #5 clk = ~clk;

    mux8to1_rr_arbiter #(.W(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .out_last_o  (out_last),
        .out_ready_i (out_ready),
        .state_o     (state),
        .ptr_o       (ptr),
        .lch_o       (lch)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules say is granted right now, -1 if none.
    function automatic int model_grant();
        if (rst) return -1;
        if (m_ov && !out_ready) return -1;
        if (m_locked) return in_valid[m_lch] ? m_lch : -1;
        for (int k = 0; k < 8; k++) begin
            if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_update();
        int g;
        g = model_grant();
        if (rst) begin
            m_ptr = 0; m_lch = 0; m_locked = 0;
            m_ov = 0; m_od = '0; m_os = 0; m_ol = 0;
            m_known = 1;
        end else if (!m_ov || out_ready) begin
            m_ov = (g >= 0);
            if (g >= 0) begin
                m_od = in_data[g*W +: W];
                m_os = g;
                m_ol = in_last[g];
                if (m_locked) begin
                    if (in_last[g]) begin
                        m_locked = 0;
                        m_ptr = (m_lch + 1) % 8;
                    end
                end else if (in_last[g]) begin
                    m_ptr = (g + 1) % 8;
                end else begin
                    m_locked = 1;
                    m_lch = g;
                end
            end
        end
    endtask

    task automatic compare_all();
        int g;
        logic [7:0] e;
        g = model_grant();
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        chk("in_ready", in_ready, e);
        if (m_known) begin
            chk("out_valid", out_valid, m_ov);
            chk("out_sel", out_sel, m_os);
            chk("out_last", out_last, m_ol);
            chk("out_data", out_data, m_od);
            chk("state", state, m_locked);
            chk("ptr", ptr, m_ptr);
            chk("lch", lch, m_lch);
        end
    endtask

    // Called at negedge+1 with inputs already driven; returns at the next negedge.
    task automatic step();
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic tick();
        #1;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        in_last = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_data(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    initial begin
        rst = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b1; in_data = '0;
        m_known = 0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) set_data(k, W'(8'h10 + k));

        // Round-robin sweep with every channel requesting single-beat packets
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ptr", ptr, 0);
        in_valid = 8'hFF; in_last = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("sweep_rdy", in_ready, 32'(1 << (i % 8)));
            step();
            chk("sweep_sel", out_sel, i % 8);
            chk("sweep_valid", out_valid, 1);
        end

        // Pointer at 3: channel 7 beats channel 0
        do_reset();
        in_valid = 8'h04; in_last = 8'hFF;
        tick();
        chk("ptr3", ptr, 3);
        in_valid = 8'h81;
        tick();
        chk("wrap_first", out_sel, 7);
        tick();
        chk("wrap_second", out_sel, 0);

        // Packet lock on channel 2 while channel 5 keeps requesting
        do_reset();
        in_valid = 8'h24;
        for (int b = 0; b < 3; b++) begin
            in_last = (b == 2) ? 8'h24 : 8'h20;
            #1;
            chk("lock_rdy", in_ready, 8'h04);
            step();
            chk("lock_sel", out_sel, 2);
        end
        #1;
        chk("after_lock_rdy", in_ready, 8'h20);
        step();
        chk("after_lock_sel", out_sel, 5);

        // Backpressure holds the output register and blocks all grants
        do_reset();
        set_data(3, 8'hA5);
        set_data(4, 8'h3C);
        in_valid = 8'h08; in_last = 8'hFF; out_ready = 1'b1;
        tick();
        chk("bp_data0", out_data, 8'hA5);
        in_valid = 8'hFF; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_rdy", in_ready, 0);
            step();
            chk("bp_data", out_data, 8'hA5);
            chk("bp_sel", out_sel, 3);
            chk("bp_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_rdy", in_ready, 8'h10);
        step();
        chk("release_sel", out_sel, 4);
        chk("release_data", out_data, 8'h3C);

        // Reset in the middle of a channel-4 packet
        do_reset();
        in_valid = 8'h10; in_last = 8'h00;
        tick();
        chk("mid_locked", state, 1);
        rst = 1'b1;
        #1;
        chk("rst_rdy_zero", in_ready, 0);
        step();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_state", state, 0);
        in_valid = 8'h12; in_last = 8'hFF;
        #1;
        chk("mid_rst_rdy", in_ready, 8'h02);
        step();
        chk("mid_rst_sel", out_sel, 1);

        // Lone channel 6 streams with no bubbles
        do_reset();
        in_valid = 8'h40; in_last = 8'hFF; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("solo_rdy", in_ready, 8'h40);
            step();
            chk("solo_sel", out_sel, 6);
            chk("solo_valid", out_valid, 1);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 3))
                0: in_valid = 8'b1 << $urandom_range(0, 7);
                1: in_valid = '0;
                default: in_valid = 8'($urandom_range(0, 255));
            endcase
            in_last = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++) set_data(k, W'($urandom));
            tick();
        end
        rst = 1'b0;
        in_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
